// File: rtl/adder_arb_pkg.sv
// Shared definitions for the adder arbiter: FSM state encoding and overflow-counter width.
package adder_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  localparam int OVF_CNT_W = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first asserted request after position last, wrapping.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   idx
);

  logic             found;
  logic [IDX_W-1:0] j;

  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    j      = '0;
    // k = NUM_REQ wraps back to last itself, so it is considered lowest priority
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = IDX_W'((int'(last) + k) % NUM_REQ);
      if (!found && req[j]) begin
        found     = 1'b1;
        idx       = j;
        onehot[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one registered adder among NUM_REQ requesters.
// Define ADDER_ARB_OVF_CNT_EN to add the saturating overflow counter (OvfCnt/OvfClr).
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic [NUM_REQ-1:0]       Req,
  input  logic [NUM_REQ*WIDTH-1:0] OpA,
  input  logic [NUM_REQ*WIDTH-1:0] OpB,
  output logic [NUM_REQ-1:0]       Gnt,
  output logic [NUM_REQ-1:0]       Done,
  output logic [WIDTH-1:0]         Result,
  output logic                     ResOvf,
`ifdef ADDER_ARB_OVF_CNT_EN
  input  logic                     OvfClr,
  output logic [OVF_CNT_W-1:0]     OvfCnt,
`endif
  output logic [WIDTH-1:0]         Add_A,
  output logic [WIDTH-1:0]         Add_B,
  output logic                     Add_En,
  input  logic [WIDTH-1:0]         Add_Sum,
  input  logic                     Add_Ovf
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_t               state;
  logic [IDX_W-1:0]     last;
  logic [NUM_REQ-1:0]   win_oh;
  logic [NUM_REQ-1:0]   pick_oh;
  logic [IDX_W-1:0]     pick_idx;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req    (Req),
    .last   (last),
    .onehot (pick_oh),
    .idx    (pick_idx)
  );

  assign Add_En = (state == ST_ISSUE);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state  <= ST_IDLE;
      last   <= IDX_W'(NUM_REQ - 1);
      win_oh <= '0;
      Gnt    <= '0;
      Done   <= '0;
      Result <= '0;
      ResOvf <= 1'b0;
      Add_A  <= '0;
      Add_B  <= '0;
    end else begin
      Gnt  <= '0;
      Done <= '0;
      case (state)
        ST_IDLE: begin
          if (|Req) begin
            Gnt    <= pick_oh;
            win_oh <= pick_oh;
            last   <= pick_idx;
            Add_A  <= OpA[pick_idx*WIDTH +: WIDTH];
            Add_B  <= OpB[pick_idx*WIDTH +: WIDTH];
            state  <= ST_ISSUE;
          end
        end
        ST_ISSUE: state <= ST_CAPTURE;
        // adder registered the operands at the end of ISSUE; its outputs are valid now
        ST_CAPTURE: begin
          Result <= Add_Sum;
          ResOvf <= Add_Ovf;
          Done   <= win_oh;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ADDER_ARB_OVF_CNT_EN
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      OvfCnt <= '0;
    end else if (OvfClr) begin
      OvfCnt <= '0;
    end else if (state == ST_CAPTURE && Add_Ovf && OvfCnt != '1) begin
      OvfCnt <= OvfCnt + 1'b1;
    end
  end
`endif

endmodule
